// File: rtl/serial_port_pkg.sv
// Shared defaults and width helpers for the serial port and its byte FIFOs.
`default_nettype none

package serial_port_pkg;

  localparam int SERIAL_WIDTH = 8;
  localparam int SERIAL_DEPTH = 8;
  localparam int SERIAL_PTR_W = $clog2(SERIAL_DEPTH);
  localparam int SERIAL_CNT_W = SERIAL_PTR_W + 1;

  // Occupancy must represent 0..depth inclusive, hence one bit wider than a pointer.
  function automatic int serial_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_port_byte_fifo.sv
// First-word fall-through byte FIFO; full/empty decisions use the count held at cycle start.
`default_nettype none

module byte_fifo
  import serial_port_pkg::*;
#(
  parameter  int DEPTH = SERIAL_DEPTH,
  parameter  int WIDTH = SERIAL_WIDTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = serial_cnt_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_ready,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_hold;
  logic             r_live;

  logic w_full;
  logic w_empty;
  logic w_do_push;
  logic w_do_pop;

  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_do_push = i_push & ~w_full;
  assign w_do_pop  = i_pop & ~w_empty;

  // r_live keeps ready low until the first edge after reset release.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_hold   <= '0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_hold   <= r_mem[r_rd_ptr];
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // When empty the output keeps showing the last byte popped.
  assign o_data  = w_empty ? r_hold : r_mem[r_rd_ptr];
  assign o_valid = ~w_empty;
  assign o_ready = r_live & ~w_full;
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/serial_port.sv
// Processor-to-link serial port: an RX and a TX byte FIFO plus sticky error flags.
`default_nettype none

module serial_port
  import serial_port_pkg::*;
#(
  parameter int DEPTH = SERIAL_DEPTH,
  parameter int WIDTH = SERIAL_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] cpu_data_in,
  input  logic             cpu_wren_in,
  input  logic             cpu_rden_in,
  output logic [WIDTH-1:0] cpu_data_out,
  output logic             cpu_valid_out,
  output logic             cpu_ready_out,
  input  logic [WIDTH-1:0] link_rx_data_in,
  input  logic             link_rx_valid_in,
  output logic             link_rx_ready_out,
  output logic [WIDTH-1:0] link_tx_data_out,
  output logic             link_tx_valid_out,
  input  logic             link_tx_ready_in,
  output logic             tx_drop_out,
  output logic             rx_underrun_out
);

  localparam int CNT_W = serial_cnt_width(DEPTH);

  logic [CNT_W-1:0] w_rx_count;
  logic [CNT_W-1:0] w_tx_count;
  logic             w_rx_empty;
  logic             w_tx_full;
  logic             w_rx_push;
  logic             w_tx_pop;
  logic             r_tx_drop;
  logic             r_rx_underrun;

  assign w_rx_push  = link_rx_valid_in & link_rx_ready_out;
  assign w_tx_pop   = link_tx_valid_out & link_tx_ready_in;
  assign w_rx_empty = (w_rx_count == '0);
  assign w_tx_full  = (w_tx_count == CNT_W'(DEPTH));

  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) rx_fifo (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (w_rx_push),
    .i_data  (link_rx_data_in),
    .i_pop   (cpu_rden_in),
    .o_data  (cpu_data_out),
    .o_valid (cpu_valid_out),
    .o_ready (link_rx_ready_out),
    .o_count (w_rx_count)
  );

  // Processor writes go straight in; the FIFO itself discards them when full.
  byte_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) tx_fifo (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_push  (cpu_wren_in),
    .i_data  (cpu_data_in),
    .i_pop   (w_tx_pop),
    .o_data  (link_tx_data_out),
    .o_valid (link_tx_valid_out),
    .o_ready (cpu_ready_out),
    .o_count (w_tx_count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tx_drop     <= 1'b0;
      r_rx_underrun <= 1'b0;
    end else begin
      r_tx_drop     <= r_tx_drop | (cpu_wren_in & w_tx_full);
      r_rx_underrun <= r_rx_underrun | (cpu_rden_in & w_rx_empty);
    end
  end

  assign tx_drop_out     = r_tx_drop;
  assign rx_underrun_out = r_rx_underrun;

endmodule

`default_nettype wire
